// File: rtl/vm_scheduler.sv
// Round-robin time-slice scheduler: sequences vm_on/vm_off pulses into the VMCS over N_VM slots.
// Optional per-slot slice weighting is enabled by defining VMSCHED_WEIGHT_EN.
module vm_scheduler #(
  parameter int N_VM    = 4,
  parameter int VMID_W  = 8,
  parameter int SLICE_W = 16,
  localparam int SLOT_W = $clog2(N_VM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we_i,
  input  logic [SLOT_W-1:0]  cfg_slot_i,
  input  logic [VMID_W-1:0]  cfg_vmid_i,
  input  logic               cfg_en_i,
  input  logic [1:0]         cfg_weight_i,
  input  logic [SLICE_W-1:0] slice_len_i,
  input  logic               sched_en_i,
  input  logic               yield_i,
  output logic               vm_on_o,
  output logic               vm_off_o,
  output logic [VMID_W-1:0]  vmid_o,
  output logic [SLOT_W-1:0]  active_slot_o,
  output logic               running_o
);

  typedef enum logic [1:0] {IDLE, SELECT, RUN, OFF} state_e;

  state_e                         state_q, state_d;
  logic [N_VM-1:0][VMID_W-1:0]    slot_vmid_q, slot_vmid_d;
  logic [N_VM-1:0]                slot_en_q, slot_en_d;
  logic [SLOT_W-1:0]              last_q, last_d;
  logic [SLOT_W-1:0]              active_q, active_d;
  logic [SLICE_W-1:0]             count_q, count_d;
  logic [VMID_W-1:0]              vmid_q, vmid_d;

  logic                           sel_found;
  logic [SLOT_W-1:0]              sel_idx;
  logic [VMID_W-1:0]              sel_vmid;
  logic [SLICE_W-1:0]             slice_base;
  logic [SLICE_W-1:0]             slice_load;

`ifdef VMSCHED_WEIGHT_EN
  logic [N_VM-1:0][1:0]           slot_wt_q, slot_wt_d;
  logic [SLICE_W+2:0]             slice_shift;
`else
  logic                           unused_weight;
  assign unused_weight = ^cfg_weight_i;
`endif

  // First enabled slot scanning forward from the one after last_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N_VM; k++) begin
      if (!sel_found && slot_en_q[(int'(last_q) + k) % N_VM]) begin
        sel_found = 1'b1;
        sel_idx   = SLOT_W'((int'(last_q) + k) % N_VM);
      end
    end
    sel_vmid = sel_found ? slot_vmid_q[sel_idx] : '0;
  end

  always_comb begin
    slice_base = (slice_len_i == '0) ? SLICE_W'(1) : slice_len_i;
`ifdef VMSCHED_WEIGHT_EN
    slice_shift = {3'b000, slice_base} << slot_wt_q[sel_idx];
    slice_load  = (|slice_shift[SLICE_W+2:SLICE_W]) ? '1 : slice_shift[SLICE_W-1:0];
`else
    slice_load  = slice_base;
`endif
  end

  always_comb begin
    state_d     = state_q;
    slot_vmid_d = slot_vmid_q;
    slot_en_d   = slot_en_q;
    last_d      = last_q;
    active_d    = active_q;
    count_d     = count_q;
    vmid_d      = vmid_q;
`ifdef VMSCHED_WEIGHT_EN
    slot_wt_d   = slot_wt_q;
`endif

    if (cfg_we_i && (int'(cfg_slot_i) < N_VM)) begin
      slot_vmid_d[cfg_slot_i] = cfg_vmid_i;
      slot_en_d[cfg_slot_i]   = cfg_en_i;
`ifdef VMSCHED_WEIGHT_EN
      slot_wt_d[cfg_slot_i]   = cfg_weight_i;
`endif
    end

    case (state_q)
      IDLE: begin
        if (sched_en_i && |slot_en_q) state_d = SELECT;
      end
      SELECT: begin
        if (sel_found) begin
          vmid_d   = sel_vmid;
          last_d   = sel_idx;
          active_d = sel_idx;
          count_d  = slice_load;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // All exit causes collapse into one transition, so only one vm_off pulse.
        if (count_q == SLICE_W'(1) || yield_i || !sched_en_i || !slot_en_q[active_q])
          state_d = OFF;
        else
          count_d = count_q - SLICE_W'(1);
      end
      OFF: begin
        state_d = (sched_en_i && |slot_en_q) ? SELECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_vmid_q <= '0;
      slot_en_q   <= '0;
      last_q      <= SLOT_W'(N_VM - 1);
      active_q    <= '0;
      count_q     <= '0;
      vmid_q      <= '0;
`ifdef VMSCHED_WEIGHT_EN
      slot_wt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slot_vmid_q <= slot_vmid_d;
      slot_en_q   <= slot_en_d;
      last_q      <= last_d;
      active_q    <= active_d;
      count_q     <= count_d;
      vmid_q      <= vmid_d;
`ifdef VMSCHED_WEIGHT_EN
      slot_wt_q   <= slot_wt_d;
`endif
    end
  end

  assign vm_on_o       = (state_q == SELECT) && sel_found;
  assign vm_off_o      = (state_q == OFF);
  assign running_o     = (state_q == RUN);
  assign active_slot_o = active_q;
  assign vmid_o        = (state_q == IDLE)   ? '0 :
                         (state_q == SELECT) ? sel_vmid : vmid_q;

endmodule

// File: tb/tb_vm_scheduler.sv
// Directed bench for vm_scheduler; weight checks are built only when VMSCHED_WEIGHT_EN is defined.
module tb_vm_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we_i;
  logic [1:0]  cfg_slot_i;
  logic [7:0]  cfg_vmid_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_weight_i;
  logic [15:0] slice_len_i;
  logic        sched_en_i;
  logic        yield_i;
  logic        vm_on_o;
  logic        vm_off_o;
  logic [7:0]  vmid_o;
  logic [1:0]  active_slot_o;
  logic        running_o;

  int total = 0;
  int bad   = 0;

  vm_scheduler #(.N_VM(4), .VMID_W(8), .SLICE_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_slot_i(cfg_slot_i), .cfg_vmid_i(cfg_vmid_i),
    .cfg_en_i(cfg_en_i), .cfg_weight_i(cfg_weight_i),
    .slice_len_i(slice_len_i), .sched_en_i(sched_en_i), .yield_i(yield_i),
    .vm_on_o(vm_on_o), .vm_off_o(vm_off_o), .vmid_o(vmid_o),
    .active_slot_o(active_slot_o), .running_o(running_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int slot, input logic [7:0] vmid, input logic en, input logic [1:0] wt);
    cfg_we_i     = 1'b1;
    cfg_slot_i   = 2'(slot);
    cfg_vmid_i   = vmid;
    cfg_en_i     = en;
    cfg_weight_i = wt;
    step();
    cfg_we_i     = 1'b0;
  endtask

  // Waits for vm_on, then measures the RUN length and checks the trailing vm_off cycle.
  task automatic run_slice(input string tag, input logic [7:0] exp_vmid, input int exp_slot,
                           input int exp_len, input int exp_wait);
    int w;
    int len;
    w = 0;
    while (!vm_on_o && w < 50) begin step(); w++; end
    chk({tag, " wait"}, w, exp_wait);
    chk({tag, " on"}, vm_on_o, 1);
    chk({tag, " vmid"}, vmid_o, exp_vmid);
    step();
    chk({tag, " slot"}, active_slot_o, exp_slot);
    len = 0;
    while (running_o && len < 70000) begin len++; step(); end
    chk({tag, " len"}, len, exp_len);
    chk({tag, " off"}, {vm_off_o, vm_on_o}, 2'b10);
    chk({tag, " off vmid"}, vmid_o, exp_vmid);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we_i = 1'b0; cfg_slot_i = '0; cfg_vmid_i = '0; cfg_en_i = 1'b0;
    cfg_weight_i = '0; slice_len_i = 16'd3; sched_en_i = 1'b0; yield_i = 1'b0;
    step(); step();
    chk("reset outs", {vm_on_o, vm_off_o, vmid_o, active_slot_o, running_o}, '0);
    rst_n = 1'b1;

    // 1: two slots alternate with slice 3
    cfg(0, 8'h11, 1'b1, 2'd0);
    cfg(1, 8'h22, 1'b1, 2'd0);
    step();
    chk("t1 idle no on", vm_on_o, 0);
    sched_en_i = 1'b1;
    run_slice("t1a", 8'h11, 0, 3, 1);
    run_slice("t1b", 8'h22, 1, 3, 1);
    run_slice("t1c", 8'h11, 0, 3, 1);
    sched_en_i = 1'b0;
    step();
    chk("t1 idle", {vm_off_o, running_o, vmid_o}, '0);

    // 2: slot 1 disabled, slot 2 enabled; order 2,0,2,0 after last=0
    cfg(1, 8'h22, 1'b0, 2'd0);
    cfg(2, 8'h33, 1'b1, 2'd0);
    sched_en_i = 1'b1;
    run_slice("t2a", 8'h33, 2, 3, 1);
    run_slice("t2b", 8'h11, 0, 3, 1);
    run_slice("t2c", 8'h33, 2, 3, 1);
    run_slice("t2d", 8'h11, 0, 3, 1);

    // 3: yield in the second RUN cycle of a 10-cycle slice
    slice_len_i = 16'd10;
    step();
    chk("t3 on", {vm_on_o, vmid_o}, {1'b1, 8'h33});
    step();
    chk("t3 run1", running_o, 1);
    step();
    yield_i = 1'b1;
    step();
    yield_i = 1'b0;
    chk("t3 off", {vm_off_o, running_o}, 2'b10);
    step();
    chk("t3 next on", {vm_on_o, vmid_o}, {1'b1, 8'h11});

    // 4: disable remaining slots mid-RUN
    step();
    cfg(2, 8'h33, 1'b0, 2'd0);
    cfg_we_i = 1'b1; cfg_slot_i = 2'd0; cfg_vmid_i = 8'h11; cfg_en_i = 1'b0;
    step();
    cfg_we_i = 1'b0;
    chk("t4 still run", running_o, 1);
    step();
    chk("t4 off", vm_off_o, 1);
    step();
    chk("t4 idle", {vm_on_o, vm_off_o, running_o, vmid_o}, '0);
    step();
    chk("t4 stay idle", {vm_on_o, running_o}, 2'b00);

    // 5: zero slice, single slot reselect, vmid rewrite, sched_en drop, reset mid-RUN
    slice_len_i = 16'd0;
    cfg(3, 8'h44, 1'b1, 2'd0);
    run_slice("t5a", 8'h44, 3, 1, 1);
    run_slice("t5b", 8'h44, 3, 1, 1);
    slice_len_i = 16'd5;
    step();
    step();
    cfg(3, 8'h55, 1'b1, 2'd0);
    chk("t5 vmid held", {running_o, vmid_o}, {1'b1, 8'h44});
    sched_en_i = 1'b0;
    step();
    chk("t5 drop off", vm_off_o, 1);
    step();
    chk("t5 drop idle", {running_o, vmid_o}, '0);
    sched_en_i = 1'b1;
    step();
    chk("t5 new vmid", {vm_on_o, vmid_o}, {1'b1, 8'h55});
    step(); step();
    rst_n = 1'b0;
    step();
    chk("t5 reset", {vm_on_o, vm_off_o, vmid_o, active_slot_o, running_o}, '0);
    rst_n = 1'b1;
    step(); step();
    chk("t5 post reset", {vm_on_o, vm_off_o, running_o}, '0);

`ifdef VMSCHED_WEIGHT_EN
    // 6: weighted slices and saturation
    slice_len_i = 16'd4;
    cfg(0, 8'h66, 1'b1, 2'd2);
    run_slice("t6a", 8'h66, 0, 16, 1);
    sched_en_i = 1'b0;
    step();
    cfg(0, 8'h66, 1'b1, 2'd3);
    slice_len_i = 16'hC000;
    sched_en_i = 1'b1;
    run_slice("t6b", 8'h66, 0, 65535, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
